// File: rtl/fp32_seq_mul.sv
// fp32_seq_mul: sequential IEEE-754 single-precision multiplier (radix-2 Booth, 26-cycle latency)
// Ports: clk, rst (sync, active-high); start, a, b in; y (registered product), busy, done (1-cycle pulse) out.
// Optional macro FP32_SPECIAL_CASE_EN: zero/inf/overflow/underflow handling; latency unchanged.
module fp32_seq_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ITER, NORM} state_t;
    state_t      state_q;
    logic [24:0] a_q, q_q, m_q;
    logic        q1_q, sgn_q, busy_q, done_q;
    logic [4:0]  cnt_q;
    logic [7:0]  ea_q, eb_q;
    logic [31:0] y_q;
    logic        sub, act, norm;
    logic [24:0] sum_d, acc_d;
    logic [7:0]  e_d;
    logic [22:0] frac_d;
    logic [31:0] y_d;

    function automatic logic [7:0] rca8(input logic [7:0] x, input logic [7:0] z, input logic ci);
        logic [7:0] s;
        logic       c;
        c = ci;
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] ^ z[i] ^ c;
            c = (x[i] & z[i]) | (c & (x[i] ^ z[i]));
        end
        return s;
    endfunction

    // Booth pair {Q[0],Q_1}: 10 subtracts M (A + ~M + 1), 01 adds M
    assign sub   = q_q[0] & ~q1_q;
    assign act   = q_q[0] ^ q1_q;
    assign sum_d = a_q + (sub ? ~m_q : m_q) + {24'd0, sub};
    assign acc_d = act ? sum_d : a_q;

    // P[47:0] = {A[22:0], Q}
    assign norm   = a_q[22];
    assign frac_d = norm ? {a_q[21:0], q_q[24]} : {a_q[20:0], q_q[24:23]};
    // unbias each exponent (-127 == +129 mod 256), add, then re-bias with normalisation carry-in
    assign e_d = rca8(rca8(rca8(ea_q, 8'd129, 1'b0), rca8(eb_q, 8'd129, 1'b0), 1'b0), 8'd127, norm);

`ifdef FP32_SPECIAL_CASE_EN
    logic [9:0] te;
    logic       zero, inf, ovf, unf;
    assign te   = {2'b0, ea_q} + {2'b0, eb_q} + {9'd0, norm} - 10'd127;
    assign zero = (ea_q == 8'd0) | (eb_q == 8'd0);
    assign inf  = (ea_q == 8'hFF) | (eb_q == 8'hFF);
    assign ovf  = ~te[9] & (te > 10'd254);
    assign unf  = te[9] | (te == 10'd0);
    assign y_d  = zero ? {sgn_q, 31'd0} :
                  (inf | ovf) ? {sgn_q, 8'hFF, 23'd0} :
                  unf ? {sgn_q, 31'd0} : {sgn_q, e_d, frac_d};
`else
    assign y_d = {sgn_q, e_d, frac_d};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= '0;
                    q_q     <= {2'b01, a[22:0]};
                    m_q     <= {2'b01, b[22:0]};
                    q1_q    <= 1'b0;
                    cnt_q   <= '0;
                    sgn_q   <= a[31] ^ b[31];
                    ea_q    <= a[30:23];
                    eb_q    <= b[30:23];
                    busy_q  <= 1'b1;
                    state_q <= ITER;
                end
                ITER: begin
                    a_q     <= {acc_d[24], acc_d[24:1]};
                    q_q     <= {acc_d[0], q_q[24:1]};
                    q1_q    <= q_q[0];
                    cnt_q   <= cnt_q + 5'd1;
                    state_q <= (cnt_q == 5'd24) ? NORM : ITER;
                end
                NORM: begin
                    y_q     <= y_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_fp32_seq_mul.sv
// tb_fp32_seq_mul: table, corner-sequence and random checks of fp32_seq_mul
module tb_fp32_seq_mul;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] a = '0, b = '0, y;
    logic        busy, done;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fp32_seq_mul dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y), .busy(busy), .done(done));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] z);
        longint      p;
        int          nrm, e;
        logic        s;
        logic [22:0] f;
        p   = longint'({1'b1, x[22:0]}) * longint'({1'b1, z[22:0]});
        nrm = int'(p >> 47);
        e   = int'(x[30:23]) + int'(z[30:23]) - 127 + nrm;
        s   = x[31] ^ z[31];
        f   = (nrm != 0) ? p[46:24] : p[45:23];
`ifdef FP32_SPECIAL_CASE_EN
        if (x[30:23] == 8'd0 || z[30:23] == 8'd0) return {s, 31'd0};
        if (x[30:23] == 8'hFF || z[30:23] == 8'hFF || e > 254) return {s, 8'hFF, 23'd0};
        if (e < 1) return {s, 31'd0};
`endif
        return {s, 8'(e), f};
    endfunction

    task automatic op(input logic [31:0] x, input logic [31:0] z, input bit spam,
                      output logic [31:0] r, output int lat);
        logic bad;
        bad = 1'b0;
        a = x; b = z; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0; r = 'x;
        for (int i = 1; i <= 40; i++) begin
            if (spam) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = i; r = y;
                break;
            end
            if (busy !== 1'b1) bad = 1'b1;
        end
        start = 1'b0;
        check("busy_during_op", {31'd0, bad}, 32'd0);
    endtask

    initial begin
        logic [31:0] r, x, z, hold;
        int          lat;
        logic        saw;
        tbl.push_back('{32'h40000000, 32'h40400000, 32'h40C00000});
        tbl.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000});
        tbl.push_back('{32'hC0000000, 32'h3F000000, 32'hBF800000});
        tbl.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000});
        tbl.push_back('{32'hC0000000, 32'hC0400000, 32'h40C00000});
        tbl.push_back('{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE});
`ifdef FP32_SPECIAL_CASE_EN
        tbl.push_back('{32'h00000000, 32'h40400000, 32'h00000000});
        tbl.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000});
        tbl.push_back('{32'h00800000, 32'h00800000, 32'h00000000});
`else
        tbl.push_back('{32'h7F000000, 32'h7F000000, 32'h3E800000});
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_y", y, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            op(tbl[i].a, tbl[i].b, 1'b0, r, lat);
            check($sformatf("vec%0d_y", i), r, tbl[i].y);
            check($sformatf("vec%0d_latency", i), lat, 32'd26);
            hold = r;
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_y_hold", i), y, hold);
        end

        op(32'h40000000, 32'h40400000, 1'b1, r, lat);
        check("spam_y", r, 32'h40C00000);
        check("spam_latency", lat, 32'd26);
        @(posedge clk); #1;
        check("spam_idle_after", {31'd0, busy}, 32'd0);

        for (int k = 0; k < 25; k++) begin
            x = $urandom; z = $urandom;
            op(x, z, 1'b0, r, lat);
            check($sformatf("rand%0d_%h_%h", k, x, z), r, model(x, z));
        end

        a = 32'h40000000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1; a = 32'h3FC00000; b = 32'h3FC00000;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_y", y, 32'd0);
        rst = 1'b0; start = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        check("abort_no_done", {31'd0, saw}, 32'd0);

        op(32'h3FC00000, 32'h3FC00000, 1'b0, r, lat);
        check("after_abort_y", r, 32'h40100000);
        check("after_abort_latency", lat, 32'd26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32_seq_mul.md
FP32_SEQ_MUL -- requirements
Module: fp32_seq_mul

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  input  1  request a multiply; sampled only while busy=0.
REQ-004 SHALL have ports: a  input  32  IEEE-754 single-precision operand A.
REQ-005 SHALL have ports: b  input  32  IEEE-754 single-precision operand B.
REQ-006 SHALL have ports: y  output  32  registered product; holds its value until the next done.
REQ-007 SHALL have ports: busy  output  1  high while an operation is in progress.
REQ-008 SHALL have ports: done  output  1  one-cycle pulse; y is valid in the same cycle.
REQ-009 SHALL have no parameters; all widths fixed.

Function
REQ-010 SHALL latch a and b on the edge where start=1 and busy=0, then set busy=1.
REQ-011 SHALL ignore start while busy=1, including on the done edge.
REQ-012 SHALL use state sequence IDLE -> ITER (25 edges) -> NORM (1 edge) -> IDLE, for a start edge N.
REQ-013 ITER SHALL run on edges N+1..N+25, NORM on edge N+26.
REQ-014 On edge N+26 SHALL register y, set done=1 and set busy=0, for a fixed latency of 26 cycles.
REQ-015 Sign SHALL be a[31] XOR b[31].
REQ-016 Exponent SHALL be unbias(ea)+unbias(eb) through an 8-bit ripple-carry adder (cin=0), where unbias(e)=e-127 mod 256.
REQ-017 The bias SHALL then be re-added: e = sum+127 mod 256.
REQ-018 The re-add of REQ-017 SHALL be incremented by 1 when the mantissa normalises.
REQ-019 Mantissa SHALL use radix-2 Booth on 25-bit operands {0,1,frac}, with a 25-bit add/subtract unit computing a+b+cin.
REQ-020 The add/subtract unit SHALL perform subtraction as A + ~M + 1.
REQ-021 Each ITER edge SHALL examine {Q[0],Q_1}: 01 adds M, 10 subtracts M, 00 or 11 does nothing.
REQ-022 After the REQ-021 action, each ITER edge SHALL do an arithmetic shift right of {A,Q,Q_1}.
REQ-023 After 25 iterations, P[47:0] of {A,Q} SHALL equal the unsigned 24x24 significand product.
REQ-024 Normalisation: if P[47]=1, fraction SHALL be P[46:24] and the exponent SHALL be incremented.
REQ-025 Normalisation: otherwise fraction SHALL be P[45:23].
REQ-026 Rounding SHALL be truncation (round toward zero).
REQ-027 done SHALL be low in all cycles other than NORM.

Reset
REQ-028 rst=1 at any edge SHALL force IDLE, busy=0, done=0, y=0x00000000 and clear the internal A/Q/M/counter.
REQ-029 Reset mid-operation SHALL abort it with no done pulse; start is ignored in the reset cycle.

Configuration
REQ-030 Macro FP32_SPECIAL_CASE_EN, defined: any operand with exponent 0 (zero or denormal) SHALL give y={sign,31'b0}.
REQ-031 With FP32_SPECIAL_CASE_EN defined: any operand with exponent 255 SHALL give y={sign,8'hFF,23'b0}.
REQ-032 With FP32_SPECIAL_CASE_EN defined: true exponent >254 SHALL give y={sign,8'hFF,23'b0}.
REQ-033 With FP32_SPECIAL_CASE_EN defined: true exponent <1 SHALL give y={sign,31'b0}.
REQ-034 With FP32_SPECIAL_CASE_EN defined: precedence SHALL be zero, then exponent 255, then overflow, then underflow.
REQ-035 Macro FP32_SPECIAL_CASE_EN undefined: no special-case logic; exponent wraps mod 256 and hidden bit is always 1.
REQ-036 Latency SHALL be identical with and without FP32_SPECIAL_CASE_EN.

Verification
REQ-037 a=0x40000000, b=0x40400000, start pulse -> done exactly 26 cycles after start edge, y=0x40C00000 (6.0).
REQ-038 a=0x3FC00000, b=0x3FC00000 -> y=0x40100000 (2.25, P[47]=1 path).
REQ-039 a=0xC0000000, b=0x3F000000 -> y=0xBF800000 (-1.0).
REQ-040 With FP32_SPECIAL_CASE_EN: a=0x00000000, b=0x40400000 -> y=0x00000000.
REQ-041 With FP32_SPECIAL_CASE_EN: a=0x7F000000, b=0x7F000000 -> y=0x7F800000.
REQ-042 Start 2.0*3.0, assert rst at edge N+10 -> busy=0, no done, y=0.
REQ-043 After REQ-042, start 1.5*1.5 -> y=0x40100000 at N'+26.
REQ-044 Start pulses during busy -> ignored, and the first result is unchanged.
